// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   Initiator side of the data-memory port. One load/store at a time is taken
//   from the pipeline memory stage, its address is probed against the memory's
//   range check (mem_dmem_error) with both flags low, and only then is a single
//   one-cycle read or write flag raised. The result is returned over a
//   valid/ready response channel. A store to a bad address never raises
//   mem_write_flag, so the array is never touched.
//
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   req_*             request channel (valid/ready, is_write, addr, wdata)
//   resp_*            response channel (valid/ready, data, err)
//   mem_addr, mem_write_data, mem_write_flag, mem_read_flag  -> memory
//   mem_valM, mem_dmem_error                                  <- memory
//   err_cnt           saturating count of errored accesses
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int DATA_WID = 32,
    parameter int CNT_WID  = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_is_write,
    input  logic [DATA_WID-1:0] req_addr,
    input  logic [DATA_WID-1:0] req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_WID-1:0] resp_data,
    output logic                resp_err,
    output logic [DATA_WID-1:0] mem_addr,
    output logic [DATA_WID-1:0] mem_write_data,
    output logic                mem_write_flag,
    output logic                mem_read_flag,
    input  logic [DATA_WID-1:0] mem_valM,
    input  logic                mem_dmem_error,
    output logic [CNT_WID-1:0]  err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_ACCESS, S_RESP} state_t;

    state_t                state_q, state_d;
    logic                  is_write_q, is_write_d;
    logic [DATA_WID-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WID-1:0]   mem_write_data_q, mem_write_data_d;
    logic                  mem_write_flag_q, mem_write_flag_d;
    logic                  mem_read_flag_q, mem_read_flag_d;
    logic [DATA_WID-1:0]   resp_data_q, resp_data_d;
    logic                  resp_err_q, resp_err_d;
    logic [CNT_WID-1:0]    err_cnt_q, err_cnt_d;

    always_comb begin
        state_d          = state_q;
        is_write_d       = is_write_q;
        mem_addr_d       = mem_addr_q;
        mem_write_data_d = mem_write_data_q;
        mem_write_flag_d = 1'b0;
        mem_read_flag_d  = 1'b0;
        resp_data_d      = resp_data_q;
        resp_err_d       = resp_err_q;
        err_cnt_d        = err_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    // mem_write_data doubles as the latched store data.
                    is_write_d       = req_is_write;
                    mem_addr_d       = req_addr;
                    mem_write_data_d = req_wdata;
                    state_d          = S_PROBE;
                end
            end
            S_PROBE: begin
                // Address has been on mem_addr for a full cycle with both
                // flags low; the memory's range check is now valid.
                if (mem_dmem_error) begin
                    resp_err_d  = 1'b1;
                    resp_data_d = '0;
                    if (err_cnt_q != {CNT_WID{1'b1}})
                        err_cnt_d = err_cnt_q + CNT_WID'(1);
                    state_d = S_RESP;
                end else begin
                    // Flags are registered: they go high exactly for ACCESS.
                    mem_write_flag_d = is_write_q;
                    mem_read_flag_d  = ~is_write_q;
                    state_d          = S_ACCESS;
                end
            end
            S_ACCESS: begin
                resp_err_d  = 1'b0;
                resp_data_d = is_write_q ? '0 : mem_valM;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (resp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Async reset drops the flags immediately, so a store caught mid-ACCESS
    // is not committed at the following edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q          <= S_IDLE;
            is_write_q       <= 1'b0;
            mem_addr_q       <= '0;
            mem_write_data_q <= '0;
            mem_write_flag_q <= 1'b0;
            mem_read_flag_q  <= 1'b0;
            resp_data_q      <= '0;
            resp_err_q       <= 1'b0;
            err_cnt_q        <= '0;
        end else begin
            state_q          <= state_d;
            is_write_q       <= is_write_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_data_q <= mem_write_data_d;
            mem_write_flag_q <= mem_write_flag_d;
            mem_read_flag_q  <= mem_read_flag_d;
            resp_data_q      <= resp_data_d;
            resp_err_q       <= resp_err_d;
            err_cnt_q        <= err_cnt_d;
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign resp_valid     = (state_q == S_RESP);
    assign resp_data      = resp_data_q;
    assign resp_err       = resp_err_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_write_flag = mem_write_flag_q;
    assign mem_read_flag  = mem_read_flag_q;
    assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Directed bench: an 11-word memory model (addresses 0..10, combinational
//   read and range error, write on posedge) sits behind the controller.
//   Inputs change on negedges or #1 after posedges; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          req_valid, req_ready, req_is_write;
    logic [DW-1:0] req_addr, req_wdata;
    logic          resp_valid, resp_ready, resp_err;
    logic [DW-1:0] resp_data;
    logic [DW-1:0] mem_addr, mem_write_data, mem_valM;
    logic          mem_write_flag, mem_read_flag, mem_dmem_error;
    logic [CW-1:0] err_cnt;

    mem_access_ctrl #(.DATA_WID(DW), .CNT_WID(CW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_write_flag(mem_write_flag), .mem_read_flag(mem_read_flag),
        .mem_valM(mem_valM), .mem_dmem_error(mem_dmem_error),
        .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;

    // Memory model
    logic [DW-1:0] mem [0:15];
    int wr_pulses = 0;
    int rd_pulses = 0;
    int cyc = 0;

    assign mem_dmem_error = (mem_addr > 32'd10);
    assign mem_valM       = mem_dmem_error ? '0 : mem[mem_addr[3:0]];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (mem_write_flag) wr_pulses <= wr_pulses + 1;
        if (mem_read_flag)  rd_pulses <= rd_pulses + 1;
        if (mem_write_flag && !mem_dmem_error) mem[mem_addr[3:0]] <= mem_write_data;
    end

    int pass_cnt = 0;
    int fail_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int acc_cyc;
    logic rr_tie = 1'b0;

    // Present a request, wait (bounded) for req_ready, return #1 after accept.
    task automatic start_req(input logic w, input logic [DW-1:0] a, input logic [DW-1:0] d);
        int t = 0;
        @(negedge CLK);
        while (!req_ready && t < 20) begin @(negedge CLK); t++; end
        if (t >= 20) chk("accept_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_is_write = w; req_addr = a; req_wdata = d;
        @(posedge CLK);
        acc_cyc = cyc;
        #1 req_valid = 1'b0;
    endtask

    // Count negedges after the accept edge until resp_valid is seen.
    task automatic wait_resp(output int n, output logic [DW-1:0] data, output logic err);
        n = 0;
        do begin @(negedge CLK); n++; end while (!resp_valid && n < 10);
        if (n >= 10) chk("resp_timeout", 32'(resp_valid), 32'd1);
        data = resp_data;
        err  = resp_err;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge CLK);
        #1 resp_ready = rr_tie;
    endtask

    task automatic do_req(input logic w, input logic [DW-1:0] a, input logic [DW-1:0] d,
                          output int n, output logic [DW-1:0] data, output logic err);
        start_req(w, a, d);
        wait_resp(n, data, err);
        finish_resp();
    endtask

    initial begin
        int            n, wr0, rd0, c0;
        logic [DW-1:0] data;
        logic          err;

        for (int i = 0; i < 16; i++) mem[i] = '0;
        RST_N = 1'b0; req_valid = 1'b0; req_is_write = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_req_ready",  32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_flags",      32'({mem_write_flag, mem_read_flag}), 32'd0);
        chk("rst_mem_addr",   mem_addr, 32'd0);
        chk("rst_resp_data",  resp_data, 32'd0);
        chk("rst_err_cnt",    32'(err_cnt), 32'd0);
        @(negedge CLK) RST_N = 1'b1;

        // Store 0xDEADBEEF to 3, then load it back
        wr0 = wr_pulses;
        do_req(1'b1, 32'd3, 32'hDEADBEEF, n, data, err);
        chk("st3_latency", 32'(n), 32'd3);
        chk("st3_err",     32'(err), 32'd0);
        chk("st3_data",    data, 32'd0);
        chk("st3_wr_pulse", 32'(wr_pulses - wr0), 32'd1);
        wr0 = wr_pulses; rd0 = rd_pulses;
        do_req(1'b0, 32'd3, 32'd0, n, data, err);
        chk("ld3_latency", 32'(n), 32'd3);
        chk("ld3_data",    data, 32'hDEADBEEF);
        chk("ld3_err",     32'(err), 32'd0);
        chk("ld3_pulses",  32'({wr_pulses - wr0, rd_pulses - rd0}), 32'({32'd0, 32'd1}));

        // Store to out-of-range address 11
        wr0 = wr_pulses; rd0 = rd_pulses;
        do_req(1'b1, 32'd11, 32'h12345678, n, data, err);
        chk("st11_latency", 32'(n), 32'd2);
        chk("st11_err",     32'(err), 32'd1);
        chk("st11_data",    data, 32'd0);
        chk("st11_err_cnt", 32'(err_cnt), 32'd1);
        chk("st11_no_flag", 32'(wr_pulses - wr0 + rd_pulses - rd0), 32'd0);

        // Stall in RESP with a competing request on the inputs
        start_req(1'b0, 32'd3, 32'd0);
        wait_resp(n, data, err);
        req_valid = 1'b1; req_is_write = 1'b1; req_addr = 32'd5; req_wdata = 32'h99;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("hold_resp_valid", 32'(resp_valid), 32'd1);
            chk("hold_resp_data",  resp_data, 32'hDEADBEEF);
            chk("hold_req_ready",  32'(req_ready), 32'd0);
            chk("hold_mem_addr",   mem_addr, 32'd3);
        end
        resp_ready = 1'b1;
        @(posedge CLK);
        #1 resp_ready = 1'b0;
        chk("hold_after_hs_ready", 32'(req_ready), 32'd1);
        chk("hold_after_hs_addr",  mem_addr, 32'd3);
        @(posedge CLK);
        #1 req_valid = 1'b0;
        chk("hold_new_addr",  mem_addr, 32'd5);
        chk("hold_new_busy",  32'(req_ready), 32'd0);
        wait_resp(n, data, err);
        chk("hold_new_latency", 32'(n), 32'd3);
        finish_resp();
        do_req(1'b0, 32'd5, 32'd0, n, data, err);
        chk("ld5_data", data, 32'h99);

        // Error counter saturation: 1 + 254 = 255, then 6 more stay at 255
        for (int i = 0; i < 254; i++) do_req(1'b0, 32'(11 + i % 5), 32'd0, n, data, err);
        chk("err_cnt_255", 32'(err_cnt), 32'd255);
        for (int i = 0; i < 6; i++) do_req(1'b0, 32'hFFFF_FFF0, 32'd0, n, data, err);
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);
        chk("err_resp_err", 32'(err), 32'd1);

        // Reset in the middle of a store's ACCESS cycle
        do_req(1'b1, 32'd2, 32'h1, n, data, err);
        start_req(1'b1, 32'd2, 32'h55);
        @(negedge CLK);                      // PROBE
        @(negedge CLK);                      // ACCESS
        chk("mid_access_wflag", 32'(mem_write_flag), 32'd1);
        wr0 = wr_pulses;
        RST_N = 1'b0;
        #1;
        chk("rst_mid_wflag",  32'(mem_write_flag), 32'd0);
        chk("rst_mid_rvalid", 32'(resp_valid), 32'd0);
        chk("rst_mid_errcnt", 32'(err_cnt), 32'd0);
        @(posedge CLK);
        @(negedge CLK) RST_N = 1'b1;
        chk("rst_mid_no_commit", 32'(wr_pulses - wr0), 32'd0);
        do_req(1'b0, 32'd2, 32'd0, n, data, err);
        chk("ld2_after_rst", data, 32'h1);

        // Back-to-back load/store/load with resp_ready tied high
        rr_tie = 1'b1; resp_ready = 1'b1;
        wr0 = wr_pulses; rd0 = rd_pulses;
        do_req(1'b0, 32'd0, 32'd0, n, data, err);
        c0 = acc_cyc;
        chk("b2b_ld0_data", data, 32'd0);
        chk("b2b_ld0_err",  32'(err), 32'd0);
        do_req(1'b1, 32'd10, 32'hA5A5_0010, n, data, err);
        chk("b2b_throughput", 32'(acc_cyc - c0), 32'd4);
        chk("b2b_st10_err",   32'(err), 32'd0);
        do_req(1'b0, 32'd0, 32'd0, n, data, err);
        chk("b2b_ld0b_data",  data, 32'd0);
        chk("b2b_pulses", 32'({wr_pulses - wr0, rd_pulses - rd0}), 32'({32'd1, 32'd2}));
        chk("b2b_err_cnt", 32'(err_cnt), 32'd0);
        rr_tie = 1'b0; resp_ready = 1'b0;
        do_req(1'b0, 32'd10, 32'd0, n, data, err);
        chk("ld10_data", data, 32'hA5A5_0010);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
